// File: rtl/cbuf_stream_reader.sv
// Read-side controller for the vector pipeline circular buffer: issues reads,
// absorbs the buffer's one-cycle read latency and re-times words into a valid/ready stream.
module cbuf_stream_reader #(
    parameter int DATA_WIDTH = 4*64,
    parameter int OUT_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               arst,
    input  logic                               buf_empty_i,
    input  logic [DATA_WIDTH-1:0]              buf_data_i,
    output logic                               buf_rd_en_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [DATA_WIDTH-1:0]              data_o,
    output logic [$clog2(OUT_DEPTH+1)-1:0]     occupancy_o,
    output logic [CNT_WIDTH-1:0]               pop_cnt_o
);

    localparam int OCC_W = $clog2(OUT_DEPTH + 1);
    localparam int CRD_W = OCC_W + 1;
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    generate
        if (OUT_DEPTH < 2) begin : g_bad_depth
            $error("cbuf_stream_reader: OUT_DEPTH must be at least 2");
        end
    endgenerate

    logic [OCC_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [OUT_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [OUT_DEPTH];

    logic             pop;
    logic [CRD_W-1:0] credit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A read is allowed only if its word is guaranteed a slot when it lands,
    // counting the word already in flight and the slot freed by this cycle's pop.
    always_comb begin
        pop         = (count_q != '0) & ready_i;
        credit      = CRD_W'(count_q) + CRD_W'(inflight_q) - CRD_W'(pop);
        buf_rd_en_o = ~arst & ~buf_empty_i & (credit < CRD_W'(OUT_DEPTH));
    end

    always_comb begin
        mem_d      = mem_q;
        tail_d     = tail_q;
        head_d     = head_q;
        count_d    = count_q;
        pop_cnt_d  = pop_cnt_q;
        inflight_d = buf_rd_en_o;

        if (inflight_q) begin
            mem_d[tail_q] = buf_data_i;
            tail_d        = ptr_inc(tail_q);
        end

        if (pop) begin
            head_d    = ptr_inc(head_q);
            pop_cnt_d = pop_cnt_q + CNT_WIDTH'(1);
        end

        case ({inflight_q, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            inflight_q <= 1'b0;
            pop_cnt_q  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= inflight_d;
            pop_cnt_q  <= pop_cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign valid_o     = (count_q != '0);
    assign data_o      = mem_q[head_q];
    assign occupancy_o = count_q;
    assign pop_cnt_o   = pop_cnt_q;

endmodule
